// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter granting two requesters exclusive use of a shared JK latch bank.
// Each command runs SETUP -> PULSE (EN_CYCLES) -> HOLD -> ACK, with every output registered.
module jk_bank_arbiter #(
    parameter int unsigned N         = 4,
    parameter int unsigned EN_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [N-1:0] j0,
    input  logic [N-1:0] k0,
    input  logic [N-1:0] j1,
    input  logic [N-1:0] k1,
    output logic         ack0,
    output logic         ack1,
    output logic [N-1:0] rdata,
    output logic         enable,
    output logic [N-1:0] j,
    output logic [N-1:0] k,
    input  logic [N-1:0] q,
    output logic         busy,
    output logic         gnt_id
);

    typedef enum logic [2:0] {StIdle, StSetup, StPulse, StHold, StAck} state_e;

    // Counter counts down to zero, so it is loaded with one less than the pulse width.
    localparam logic [3:0] CntLoad = 4'(EN_CYCLES - 1);

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [N-1:0] cmd_j_q, cmd_j_d;
    logic [N-1:0] cmd_k_q, cmd_k_d;
    logic [N-1:0] rdata_q, rdata_d;
    logic [N-1:0] j_q, j_d;
    logic [N-1:0] k_q, k_d;
    logic         gnt_q, gnt_d;
    logic         en_q, en_d;
    logic         ack0_q, ack0_d;
    logic         ack1_q, ack1_d;
    logic         busy_q, busy_d;
    logic         win;
    logic         drive;

    // Next-state, arbitration and next-output logic; outputs derive from the next state
    // so that they are all straight flop outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_j_d = cmd_j_q;
        cmd_k_d = cmd_k_q;
        rdata_d = rdata_q;
        gnt_d   = gnt_q;
        // Round-robin: on contention the requester that did not own the bank last wins.
        win     = (req0 && req1) ? ~gnt_q : req1;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    state_d = StSetup;
                    gnt_d   = win;
                    cmd_j_d = win ? j1 : j0;
                    cmd_k_d = win ? k1 : k0;
                end
            end
            StSetup: begin
                state_d = StPulse;
                cnt_d   = CntLoad;
            end
            StPulse: begin
                if (cnt_q == 4'd0) begin
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHold: begin
                state_d = StAck;
                rdata_d = q;
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        drive  = (state_d == StSetup) || (state_d == StPulse);
        j_d    = drive ? cmd_j_d : '0;
        k_d    = drive ? cmd_k_d : '0;
        en_d   = (state_d == StPulse);
        ack0_d = (state_d == StAck) && !gnt_d;
        ack1_d = (state_d == StAck) && gnt_d;
        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset aborts any command in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            cmd_j_q <= '0;
            cmd_k_q <= '0;
            rdata_q <= '0;
            gnt_q   <= 1'b1;
            j_q     <= '0;
            k_q     <= '0;
            en_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_j_q <= cmd_j_d;
            cmd_k_q <= cmd_k_d;
            rdata_q <= rdata_d;
            gnt_q   <= gnt_d;
            j_q     <= j_d;
            k_q     <= k_d;
            en_q    <= en_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
        end
    end

    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign rdata  = rdata_q;
    assign enable = en_q;
    assign j      = j_q;
    assign k      = k_q;
    assign busy   = busy_q;
    assign gnt_id = gnt_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: instance A (EN_CYCLES=1) and instance B (EN_CYCLES=3),
// each driving its own behavioural JK latch bank.
module tb_jk_bank_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req0, req1, req1b;
    logic [3:0] j0, k0, j1, k1;
    logic       bank_clr;

    logic       ack0a, ack1a, ena, busya, gnta;
    logic [3:0] rdataa, ja, ka, qa;
    logic       ack0b, ack1b, enb, busyb, gntb;
    logic [3:0] rdatab, jb, kb, qb;

    jk_bank_arbiter #(.N(4), .EN_CYCLES(1)) u_dut_a (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .j0(j0), .k0(k0), .j1(j1), .k1(k1),
        .ack0(ack0a), .ack1(ack1a), .rdata(rdataa), .enable(ena),
        .j(ja), .k(ka), .q(qa), .busy(busya), .gnt_id(gnta)
    );

    jk_bank_arbiter #(.N(4), .EN_CYCLES(3)) u_dut_b (
        .clk(clk), .rst(rst), .req0(1'b0), .req1(req1b),
        .j0(j0), .k0(k0), .j1(j1), .k1(k1),
        .ack0(ack0b), .ack1(ack1b), .rdata(rdatab), .enable(enb),
        .j(jb), .k(kb), .q(qb), .busy(busyb), .gnt_id(gntb)
    );

    // Behavioural JK latch banks: update once per clock while enabled.
    always @(posedge clk) begin
        if (bank_clr) begin
            qa <= 4'b0;
            qb <= 4'b0;
        end else begin
            if (ena) qa <= (ja & ~qa) | (~ka & qa);
            if (enb) qb <= (jb & ~qb) | (~kb & qb);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       id;
        logic [3:0] rdata;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] pred_q;
    int         checks   = 0;
    int         failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Predict instance A's bank after one single-cycle pulse and queue the expected ack.
    task automatic push(input logic id, input logic [3:0] jj, input logic [3:0] kk);
        pred_q = (jj & ~pred_q) | (~kk & pred_q);
        sb.push_back('{id: id, rdata: pred_q});
    endtask

    // Pop one expectation per ack; a requester drops req after its last expected ack.
    task automatic drain(input int budget, input int gap, input int rem0_in, input int rem1_in);
        int   rem0 = rem0_in;
        int   rem1 = rem1_in;
        int   last = -1;
        exp_t e;
        for (int c = 0; c < budget && sb.size() > 0; c++) begin
            @(negedge clk);
            if (ack0a || ack1a) begin
                chk("ack_onehot", {31'b0, ack0a & ack1a}, 32'd0);
                e = sb.pop_front();
                chk("ack_id", {31'b0, ack1a}, {31'b0, e.id});
                chk("ack_rdata", {28'b0, rdataa}, {28'b0, e.rdata});
                if (gap > 0 && last >= 0) chk("ack_gap", cyc - last, gap);
                last = cyc;
                if (ack0a) begin
                    rem0--;
                    if (rem0 <= 0) req0 = 1'b0;
                end
                if (ack1a) begin
                    rem1--;
                    if (rem1 <= 0) req1 = 1'b0;
                end
            end
        end
        if (sb.size() != 0) begin
            chk("sb_timeout", sb.size(), 32'd0);
            sb.delete();
            req0 = 1'b0;
            req1 = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        chk("idle_busy", {31'b0, busya}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   en_tab[6];
        int   jb_tab[6];
        int   ak_tab[6];
        en_tab = '{0, 1, 1, 1, 0, 0};
        jb_tab = '{15, 15, 15, 15, 0, 0};
        ak_tab = '{0, 0, 0, 0, 0, 1};

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; req1b = 1'b0;
        j0 = '0; k0 = '0; j1 = '0; k1 = '0; bank_clr = 1'b1;
        pred_q = 4'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_enable", {31'b0, ena}, 32'd0);
        chk("rst_j", {28'b0, ja}, 32'd0);
        chk("rst_busy", {31'b0, busya}, 32'd0);
        chk("rst_gnt", {31'b0, gnta}, 32'd1);
        chk("rst_rdata", {28'b0, rdataa}, 32'd0);
        chk("rst_acks", {30'b0, ack0a, ack1a}, 32'd0);
        chk("rst_gnt_b", {31'b0, gntb}, 32'd1);
        bank_clr = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Single requester, EN_CYCLES=1: cycle-exact sequence.
        j0 = 4'b0011; k0 = 4'b1100; req0 = 1'b1;
        push(1'b0, j0, k0);
        @(negedge clk);
        chk("setup_en", {31'b0, ena}, 32'd0);
        chk("setup_j", {28'b0, ja}, 32'h3);
        chk("setup_busy", {31'b0, busya}, 32'd1);
        chk("setup_gnt", {31'b0, gnta}, 32'd0);
        @(negedge clk);
        chk("pulse_en", {31'b0, ena}, 32'd1);
        chk("pulse_jk", {24'b0, ja, ka}, 32'h3c);
        @(negedge clk);
        chk("hold_en", {31'b0, ena}, 32'd0);
        chk("hold_jk", {24'b0, ja, ka}, 32'h00);
        chk("hold_ack", {30'b0, ack0a, ack1a}, 32'd0);
        @(negedge clk);
        e = sb.pop_front();
        chk("ack0_e3", {30'b0, ack0a, ack1a}, 32'd2);
        chk("rdata_e3", {28'b0, rdataa}, {28'b0, e.rdata});
        chk("bank_q", {28'b0, qa}, 32'h3);
        req0 = 1'b0;
        @(negedge clk);
        chk("after_ack0", {31'b0, ack0a}, 32'd0);
        chk("after_busy", {31'b0, busya}, 32'd0);

        // Contention after reset: 0 first, 1 five cycles later, gnt_id ends at 1.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        j0 = 4'b0101; k0 = 4'b0000; j1 = 4'b0000; k1 = 4'b0001;
        push(1'b0, j0, k0);
        push(1'b1, j1, k1);
        req0 = 1'b1; req1 = 1'b1;
        drain(40, 5, 1, 1);
        chk("contend_gnt", {31'b0, gnta}, 32'd1);

        // Both held for four commands: grants alternate 0,1,0,1.
        j0 = 4'b1001; k0 = 4'b0100; j1 = 4'b0110; k1 = 4'b1001;
        push(1'b0, j0, k0);
        push(1'b1, j1, k1);
        push(1'b0, j0, k0);
        push(1'b1, j1, k1);
        req0 = 1'b1; req1 = 1'b1;
        drain(80, 5, 2, 2);

        // req1 raised while busy with requester 0 is granted on the first IDLE edge.
        j0 = 4'b1111; k0 = 4'b0000;
        push(1'b0, j0, k0);
        req0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        j1 = 4'b0000; k1 = 4'b0101;
        push(1'b1, j1, k1);
        req1 = 1'b1;
        drain(40, 5, 1, 1);

        // Reset during PULSE aborts: enable falls at once, no ack, bank untouched.
        j0 = 4'b1111; k0 = 4'b1111; req0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_pulse_en", {31'b0, ena}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_en_async", {31'b0, ena}, 32'd0);
        chk("abort_busy_async", {31'b0, busya}, 32'd0);
        chk("abort_j_async", {28'b0, ja}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_no_ack", {30'b0, ack0a, ack1a}, 32'd0);
        end
        chk("abort_bank", {28'b0, qa}, {28'b0, pred_q});
        chk("abort_gnt", {31'b0, gnta}, 32'd1);
        rst = 1'b0;
        push(1'b0, j0, k0);
        drain(20, 0, 1, 0);

        // Instance B, EN_CYCLES=3 toggle: enable exactly 3 cycles, ack1 at E+5.
        j1 = 4'b1111; k1 = 4'b1111; req1b = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("b_enable", {31'b0, enb}, en_tab[c]);
            chk("b_j", {28'b0, jb}, jb_tab[c]);
            chk("b_k", {28'b0, kb}, jb_tab[c]);
            chk("b_ack1", {31'b0, ack1b}, ak_tab[c]);
            chk("b_ack0", {31'b0, ack0b}, 32'd0);
        end
        chk("b_rdata", {28'b0, rdatab}, 32'hf);
        chk("b_gnt", {31'b0, gntb}, 32'd1);
        req1b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b_idle", {31'b0, busyb}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jk_bank_arbiter.md
JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

Interface
REQ-001 Parameter N, 4, width of the shared JK latch bank (bits).
REQ-002 Parameter EN_CYCLES, 1, width of the enable pulse in clock cycles (legal range 1..15).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 req0 / req1  input  1 each  command request from requester 0 / 1; level, held until ack.
REQ-006 j0, k0 / j1, k1  input  N each  per-bit JK command of requester 0 / 1.
REQ-007 ack0 / ack1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-008 rdata  output  N  latch bank q captured at end of the granted command.
REQ-009 enable  output  1  enable to the shared JK latch bank.
REQ-010 j, k  output  N each  J/K drive to the shared latch bank.
REQ-011 q  input  N  current outputs of the shared latch bank.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 gnt_id  output  1  index of the requester that owns or last owned the bank.

Function
REQ-014 FSM states IDLE, SETUP, PULSE, HOLD, ACK; encoding is free.
REQ-015 IDLE: no req -> stay; any req -> grant on this edge, go to SETUP.
REQ-016 Arbitration is round-robin: one req -> grant it; both -> grant the requester not equal to gnt_id.
REQ-017 On the grant edge: capture the winner's j/k into internal registers and update gnt_id. Requester inputs are don't-care after grant until its ack.
REQ-018 SETUP (1 cycle): j/k driven from the captured command; enable=0; next state PULSE.
REQ-019 PULSE (exactly EN_CYCLES cycles): enable=1; j/k unchanged; then go to HOLD.
REQ-020 HOLD (1 cycle): enable=0; j=k=0; q sampled into rdata on the exit edge; next state ACK.
REQ-021 ACK (1 cycle): ack of the granted requester =1, other ack =0; next state IDLE.
REQ-022 Outside SETUP and PULSE: j=k=0. Outside PULSE: enable=0. All outputs are registered and glitch-free.
REQ-023 Latency: grant at edge E, enable high from edge E+1 to edge E+1+EN_CYCLES. ack high from edge E+2+EN_CYCLES for one cycle.
REQ-024 A requester still asserting req in the IDLE cycle after its ack is treated as a new command.
REQ-025 Minimum spacing between grants is 4+EN_CYCLES cycles.
REQ-026 Requests arriving while busy are not lost; they are evaluated at the next IDLE.
REQ-027 Simultaneous new req and ack on the same cycle: the ack completes the current command; the new req is arbitrated in IDLE.
REQ-028 EN_CYCLES counter: 4 bits; loaded on entry to PULSE; no wrap beyond EN_CYCLES.

Reset
REQ-029 While rst=1 the outputs are forced immediately, independent of clk:
- state = IDLE, enable = 0, j = k = 0
- ack0 = ack1 = 0, busy = 0, rdata = 0
- gnt_id = 1, so requester 0 wins the first contention.
REQ-030 Reset mid-command aborts the command: no ack is issued and the latch bank is left unmodified beyond the pulse already given. The first grant after reset release follows REQ-016.

Verification
REQ-031 Single requester, N=4, EN_CYCLES=1: req0=1, j0=4'b0011, k0=4'b1100, q starts 0 -> enable high 1 cycle at E+1, then bank q=4'b0011, ack0 at E+3, rdata=4'b0011.
REQ-032 Contention after reset: req0=req1=1 in the same cycle. Required sequence:
- requester 0 is served first, ack0;
- requester 1 is served 5 cycles later, ack1;
- gnt_id ends at 1.
REQ-033 Both requesters held high for 4 commands -> grants alternate 0,1,0,1; ack never on both outputs in one cycle.
REQ-034 EN_CYCLES=3, toggle (j1=k1=4'b1111) -> enable high exactly 3 cycles, j/k zero before and after, ack1 at E+5.
REQ-035 rst asserted during PULSE -> enable drops to 0 asynchronously, busy=0, no ack pulse. Next req0 is granted normally.
REQ-036 req1 raised while busy serving requester 0 -> granted on the first IDLE edge after ack0; req1 is not dropped.
